// File: rtl/cmp_pkg.sv
// Shared types and constants for the shared-comparator arbiter slice.
package cmp_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_EXEC = ST_EXEC,
        S_RESP = ST_RESP
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational unsigned magnitude comparator with one-hot gt/eq/lt.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one comparator between NUM_REQ requesters,
// returning tagged one-hot flags over a valid/ready response channel.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_gt,
    output logic                     rsp_eq,
    output logic                     rsp_lt,
    output logic [7:0]               op_count
);

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    state_t           state_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   grant_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    cmp_flags_t       flags_reg;
    logic             rsp_valid_reg;
    logic [7:0]       op_count_reg;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   rr_ptr_next;
    logic [IDW:0]     cand;
    logic             core_gt;
    logic             core_eq;
    logic             core_lt;

    // Search upward from rr_ptr with wrap; one extra bit keeps the sum exact
    // for non-power-of-two NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // Grant is withheld during reset so no producer sees a phantom transfer.
    always_comb begin
        req_ready = '0;
        if (!rst && state_reg == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign rr_ptr_next = (grant_reg == IDW'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .a  (op_a_reg),
        .b  (op_b_reg),
        .gt (core_gt),
        .eq (core_eq),
        .lt (core_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            rsp_id_reg    <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            flags_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            op_count_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_found) begin
                        op_a_reg  <= a_arr[grant_idx];
                        op_b_reg  <= b_arr[grant_idx];
                        grant_reg <= grant_idx;
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    flags_reg     <= {core_gt, core_eq, core_lt};
                    rsp_id_reg    <= grant_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= S_RESP;
                end
                S_RESP: begin
                    // Pointer moves only on acceptance, so a stalled response
                    // cannot starve the requester behind it.
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rr_ptr_reg    <= rr_ptr_next;
                        op_count_reg  <= op_count_reg + 8'd1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_gt    = flags_reg.gt;
    assign rsp_eq    = flags_reg.eq;
    assign rsp_lt    = flags_reg.lt;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: one task per scenario, inline checks.
module tb_cmp_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_gt;
    logic        rsp_eq;
    logic        rsp_lt;
    logic [7:0]  op_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_count = 8'd0;

    cmp_share_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .rsp_lt    (rsp_lt),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Inputs change just after the falling edge; outputs are read 1ns later.
    task automatic apply_reset;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        exp_count = 8'd0;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready != 4'b0000) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({req_ready, rsp_valid, rsp_id} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b valid=%b id=%0d, required 0", req_ready, rsp_valid, rsp_id);
        end
        checks++;
        if ({rsp_gt, rsp_eq, rsp_lt, op_count} !== 11'b0) begin
            errors++;
            $display("FAIL reset_data: flags=%b%b%b count=%0d, required 0", rsp_gt, rsp_eq, rsp_lt, op_count);
        end
    endtask

    task automatic test_single;
        req_valid = 4'b0001; req_a[3:0] = 4'b0001; req_b[3:0] = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL t1_grant: ready=%b required 0001", req_ready);
        end
        @(negedge clk); req_valid = '0; #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL t1_exec: valid=%b ready=%b required 0/0000", rsp_valid, req_ready);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {1'b1, 2'd0, 3'b001}) begin
            errors++;
            $display("FAIL t1_rsp: valid=%b id=%0d flags=%b%b%b required 1/0/001", rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt);
        end
        $display("txn t1 id=%0d flags=%b%b%b", rsp_id, rsp_gt, rsp_eq, rsp_lt);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0; #1;
        exp_count++;
        checks++;
        if (op_count !== exp_count || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL t1_count: count=%0d valid=%b required %0d/0", op_count, rsp_valid, exp_count);
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_f [4];
        logic [3:0] exp_rdy;
        int         id;
        bit         ok;
        apply_reset();
        exp_f[0] = 3'b001; exp_f[1] = 3'b100; exp_f[2] = 3'b010; exp_f[3] = 3'b100;
        req_a = {4'b1000, 4'b1001, 4'b1010, 4'b0000};
        req_b = {4'b0100, 4'b1001, 4'b0111, 4'b0001};
        req_valid = 4'b1111; rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            id = g % 4;
            exp_rdy = 4'b0001 << id;
            wait_grant(ok);
            checks++;
            if (!ok || req_ready !== exp_rdy) begin
                errors++; $display("FAIL t2_grant%0d: ready=%b required %b", g, req_ready, exp_rdy);
            end
            @(negedge clk); #1;
            wait_rsp(ok);
            checks++;
            if (!ok || rsp_id !== 2'(id) || {rsp_gt, rsp_eq, rsp_lt} !== exp_f[id]) begin
                errors++;
                $display("FAIL t2_rsp%0d: id=%0d flags=%b%b%b required %0d/%b", g, rsp_id, rsp_gt, rsp_eq, rsp_lt, id, exp_f[id]);
            end
            $display("txn t2 id=%0d flags=%b%b%b", rsp_id, rsp_gt, rsp_eq, rsp_lt);
            exp_count++;
            @(negedge clk); #1;
        end
        req_valid = '0; rsp_ready = 1'b0;
        checks++;
        if (op_count !== exp_count) begin
            errors++; $display("FAIL t2_count: count=%0d required %0d", op_count, exp_count);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        req_valid = 4'b1000; req_a[15:12] = 4'b1111; req_b[15:12] = 4'b0000; rsp_ready = 1'b0;
        #1;
        wait_grant(ok);
        checks++;
        if (!ok || req_ready !== 4'b1000) begin
            errors++; $display("FAIL t3_grant: ready=%b required 1000", req_ready);
        end
        @(negedge clk); req_valid = 4'b1111; #1;
        wait_rsp(ok);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (!ok || {rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, req_ready} !== {1'b1, 2'd3, 3'b100, 4'b0000}) begin
                errors++;
                $display("FAIL t3_hold%0d: valid=%b id=%0d flags=%b%b%b ready=%b required 1/3/100/0000",
                         c, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, req_ready);
            end
            if (c < 5) begin
                @(negedge clk); #1;
            end
        end
        $display("txn t3 id=%0d flags=%b%b%b", rsp_id, rsp_gt, rsp_eq, rsp_lt);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0; #1;
        exp_count++;
        checks++;
        if (rsp_valid !== 1'b0 || op_count !== exp_count || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL t3_accept: valid=%b count=%0d ready=%b required 0/%0d/0001", rsp_valid, op_count, req_ready, exp_count);
        end
        req_valid = '0;
        #1;
    endtask

    task automatic test_operand_latch;
        bit ok;
        req_valid = 4'b0100; req_a[11:8] = 4'b0101; req_b[11:8] = 4'b0110;
        #1;
        wait_grant(ok);
        checks++;
        if (!ok || req_ready !== 4'b0100) begin
            errors++; $display("FAIL t4_grant: ready=%b required 0100", req_ready);
        end
        @(negedge clk); req_valid = '0; req_a = 16'hFFFF; req_b = 16'h0000; #1;
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_id !== 2'd2 || {rsp_gt, rsp_eq, rsp_lt} !== 3'b001) begin
            errors++; $display("FAIL t4_rsp: id=%0d flags=%b%b%b required 2/001", rsp_id, rsp_gt, rsp_eq, rsp_lt);
        end
        $display("txn t4 id=%0d flags=%b%b%b", rsp_id, rsp_gt, rsp_eq, rsp_lt);
        rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0; #1;
        exp_count++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        for (int s = 0; s < 2; s++) begin
            req_valid = (s == 0) ? 4'b0010 : 4'b0100;
            #1;
            wait_grant(ok);
            checks++;
            if (!ok || req_ready !== req_valid) begin
                errors++; $display("FAIL t5_grant%0d: ready=%b required %b", s, req_ready, req_valid);
            end
            @(negedge clk); req_valid = '0; #1;
            if (s == 1) begin
                @(negedge clk); #1;
                checks++;
                if (rsp_valid !== 1'b1) begin
                    errors++; $display("FAIL t5_resp_state: valid=%b required 1", rsp_valid);
                end
            end
            rst = 1'b1;
            @(negedge clk); #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, op_count} !== 18'b0) begin
                errors++;
                $display("FAIL t5_zero%0d: ready=%b valid=%b id=%0d flags=%b%b%b count=%0d required 0",
                         s, req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, op_count);
            end
            rst = 1'b0; exp_count = 8'd0;
            seen = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); #1;
                if (rsp_valid !== 1'b0) seen = 1'b1;
            end
            checks++;
            if (seen) begin
                errors++; $display("FAIL t5_no_rsp%0d: response seen after reset, required none", s);
            end
            req_valid = 4'b1111; #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++; $display("FAIL t5_next%0d: ready=%b required 0001", s, req_ready);
            end
            req_valid = '0; #1;
            $display("txn t5 reset case %0d", s);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] ea, eb;
        logic [2:0] ef;
        logic [3:0] exp_rdy;
        int         id;
        bit         ok;
        apply_reset();
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            id = n % 4;
            req_a = 16'($urandom);
            req_b = (n % 5 == 0) ? req_a : 16'($urandom);
            #1;
            exp_rdy = 4'b0001 << id;
            ea = req_a[id*4 +: 4]; eb = req_b[id*4 +: 4];
            ef = {ea > eb, ea == eb, ea < eb};
            wait_grant(ok);
            checks++;
            if (!ok || req_ready !== exp_rdy) begin
                errors++; $display("FAIL t6_grant%0d: ready=%b required %b", n, req_ready, exp_rdy);
            end
            @(negedge clk); req_a = 16'($urandom); #1;
            wait_rsp(ok);
            checks++;
            if (!ok || $countones({rsp_gt, rsp_eq, rsp_lt}) != 1) begin
                errors++; $display("FAIL t6_onehot%0d: flags=%b%b%b required one-hot", n, rsp_gt, rsp_eq, rsp_lt);
            end
            checks++;
            if (rsp_id !== 2'(id) || {rsp_gt, rsp_eq, rsp_lt} !== ef) begin
                errors++;
                $display("FAIL t6_rsp%0d: id=%0d flags=%b%b%b required %0d/%b", n, rsp_id, rsp_gt, rsp_eq, rsp_lt, id, ef);
            end
            $display("txn t6 n=%0d id=%0d a=%h b=%h flags=%b%b%b", n, rsp_id, ea, eb, rsp_gt, rsp_eq, rsp_lt);
            @(negedge clk); #1;
            exp_count++;
            if (n == 254) begin
                checks++;
                if (op_count !== 8'd255) begin
                    errors++; $display("FAIL t6_count255: count=%0d required 255", op_count);
                end
            end
        end
        req_valid = '0; rsp_ready = 1'b0;
        checks++;
        if (op_count !== 8'd0 || op_count !== exp_count) begin
            errors++; $display("FAIL t6_wrap: count=%0d required 0", op_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_operand_latch();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
